// File: rtl/coax_rx_frame_buffer.sv
// Frame buffer between coax_rx and the host read port.
// First-word fall-through FIFO in an inferred RAM, with frame length tracking,
// a sticky first-error latch with its code, fill level reporting and a host flush.
module coax_rx_frame_buffer #(
  parameter int WIDTH       = 10,
  parameter int DEPTH       = 256,
  parameter int ALMOST_FULL = DEPTH - 16,
  parameter int MULTI_FRAME = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx_active,
  input  logic                     rx_error,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_strobe,
  input  logic                     clear,
  input  logic                     read_strobe,
  output logic [WIDTH-1:0]         data,
  output logic                     error,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   frame_length
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [WIDTH-1:0] ERR_OVERFLOW = WIDTH'(8);

  typedef enum logic [1:0] {IDLE, RECEIVE, ERROR, DRAIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt, frame_cnt;
  logic             prev_active;
  logic             err_flag;
  logic [WIDTH-1:0] err_code;

  logic rise, fall, is_empty, is_full, in_rx;
  logic pop, push, ovf_strobe, start_ovf, rx_err_take;

  assign rise      = rx_active & ~prev_active;
  assign fall      = ~rx_active & prev_active;
  assign is_empty  = (cnt == '0);
  assign is_full   = (cnt == CW'(DEPTH));
  assign in_rx     = (state == RECEIVE);

  // A pop is only honoured with data present and no latched error; clear wins.
  assign pop         = read_strobe & ~is_empty & ~err_flag & ~clear;
  // Writing into a full FIFO is fine if the head leaves in the same cycle.
  assign push        = in_rx & rx_strobe & ~rx_error & ~clear & (~is_full | pop);
  assign ovf_strobe  = in_rx & rx_strobe & is_full & ~pop;
  assign start_ovf   = (MULTI_FRAME == 0) & ~is_empty;
  // The first error sticks; DRAIN deliberately ignores the receiver.
  assign rx_err_take = rx_error & (state != DRAIN) & (state != ERROR);

  // Storage write port; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  // Pointers and exact occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // Frame/error state machine with registered frame_done/frame_length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      prev_active  <= 1'b0;
      err_flag     <= 1'b0;
      err_code     <= '0;
      frame_cnt    <= '0;
      frame_done   <= 1'b0;
      frame_length <= '0;
    end else begin
      prev_active <= rx_active;
      frame_done  <= 1'b0;
      if (clear) begin
        err_flag  <= 1'b0;
        err_code  <= '0;
        frame_cnt <= '0;
        state     <= rx_active ? DRAIN : IDLE;
      end else if (rx_err_take) begin
        state    <= ERROR;
        err_flag <= 1'b1;
        err_code <= rx_data;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              if (start_ovf) begin
                state    <= ERROR;
                err_flag <= 1'b1;
                err_code <= ERR_OVERFLOW;
              end else begin
                state     <= RECEIVE;
                frame_cnt <= '0;
              end
            end
          end
          RECEIVE: begin
            if (ovf_strobe) begin
              state    <= ERROR;
              err_flag <= 1'b1;
              err_code <= ERR_OVERFLOW;
            end else if (fall) begin
              // A word strobed on the falling-edge cycle still belongs to the frame.
              state        <= IDLE;
              frame_done   <= 1'b1;
              frame_length <= frame_cnt + CW'(push);
            end else if (push) begin
              frame_cnt <= frame_cnt + CW'(1);
            end
          end
          ERROR:   state <= ERROR;
          DRAIN:   if (!rx_active) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Status and read data are all derived from registers.
  always_comb begin
    data = '0;
    if (err_flag)       data = err_code;
    else if (!is_empty) data = mem[rd_ptr];
  end

  assign error       = err_flag;
  assign empty       = is_empty;
  assign full        = is_full;
  assign almost_full = (cnt >= CW'(ALMOST_FULL));
  assign count       = cnt;

endmodule

// File: tb/tb_coax_rx_frame_buffer.sv
// Scoreboard bench for coax_rx_frame_buffer: directed frames push expected words
// and frame lengths into queues; monitors pop and compare on pops and frame_done.
module tb_coax_rx_frame_buffer;
  localparam int W  = 10;
  localparam int D  = 4;
  localparam int CW = 3;

  logic clk = 1'b0, reset_n = 1'b0;
  logic rx_active = 1'b0, rx_error = 1'b0, rx_strobe = 1'b0;
  logic clear = 1'b0, read_strobe = 1'b0;
  logic [W-1:0] rx_data = '0;

  logic [W-1:0]  data, m_data;
  logic          error, empty, full, almost_full, frame_done;
  logic          m_error, m_empty, m_full, m_almost_full, m_frame_done;
  logic [CW-1:0] count, frame_length, m_count, m_frame_length;

  coax_rx_frame_buffer #(.WIDTH(W), .DEPTH(D), .ALMOST_FULL(3), .MULTI_FRAME(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .rx_active(rx_active), .rx_error(rx_error),
    .rx_data(rx_data), .rx_strobe(rx_strobe), .clear(clear), .read_strobe(read_strobe),
    .data(data), .error(error), .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .frame_done(frame_done), .frame_length(frame_length));

  coax_rx_frame_buffer #(.WIDTH(W), .DEPTH(D), .ALMOST_FULL(3), .MULTI_FRAME(1)) u_mf (
    .clk(clk), .reset_n(reset_n), .rx_active(rx_active), .rx_error(rx_error),
    .rx_data(rx_data), .rx_strobe(rx_strobe), .clear(clear), .read_strobe(read_strobe),
    .data(m_data), .error(m_error), .empty(m_empty), .full(m_full),
    .almost_full(m_almost_full), .count(m_count), .frame_done(m_frame_done),
    .frame_length(m_frame_length));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  int           len_q[$];
  logic [W-1:0] exp_w;
  int           exp_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Data monitor: every accepted pop must match the next expected word.
  always @(negedge clk) begin
    if (reset_n && read_strobe && !empty && !error) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got %0h expected none", data);
      end else begin
        exp_w = exp_q.pop_front();
        if (data !== exp_w) begin
          fails++;
          $display("FAIL pop_data: got %0h expected %0h", data, exp_w);
        end
      end
    end
  end

  // Frame monitor: every frame_done pulse must match the next expected length.
  always @(negedge clk) begin
    if (frame_done) begin
      tests++;
      if (len_q.size() == 0) begin
        fails++;
        $display("FAIL frame_done_unexpected: got len %0d expected no pulse", frame_length);
      end else begin
        exp_l = len_q.pop_front();
        if (int'(frame_length) != exp_l) begin
          fails++;
          $display("FAIL frame_length: got %0d expected %0d", frame_length, exp_l);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [W-1:0] w, input bit keep);
    rx_data = w;
    rx_strobe = 1'b1;
    if (keep) exp_q.push_back(w);
    cyc();
    rx_strobe = 1'b0;
  endtask

  task automatic pop();
    read_strobe = 1'b1;
    cyc();
    read_strobe = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) cyc();
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_error", error, 0);
    chk("rst_data", data, 0);
    chk("rst_full", full, 0);
    reset_n = 1'b1;
    cyc();

    // Clean 3-word frame, then drain in order
    rx_active = 1'b1; cyc();
    strobe(10'h101, 1); strobe(10'h102, 1); strobe(10'h103, 1);
    chk("f1_count", count, 3);
    chk("f1_afull", almost_full, 1);
    len_q.push_back(3);
    rx_active = 1'b0; cyc();
    chk("f1_done", frame_done, 1);
    cyc();
    chk("f1_done_pulse", frame_done, 0);
    chk("f1_len_held", frame_length, 3);
    pop(); pop(); pop();
    chk("f1_empty", empty, 1);
    chk("f1_data0", data, 0);
    pop();  // pop while empty is harmless
    chk("f1_empty_pop_err", error, 0);

    // Overflow on 5th strobe into DEPTH=4
    rx_active = 1'b1; cyc();
    strobe(10'h201, 0); strobe(10'h202, 0); strobe(10'h203, 0); strobe(10'h204, 0);
    chk("ovf_full", full, 1);
    strobe(10'h205, 0);
    chk("ovf_error", error, 1);
    chk("ovf_code", data, 10'h008);
    chk("ovf_count", count, 4);
    pop();
    chk("ovf_pop_ignored", count, 4);
    rx_active = 1'b0; cyc();
    chk("ovf_no_done", frame_done, 0);
    do_clear();
    chk("ovf_clr_err", error, 0);
    chk("ovf_clr_empty", empty, 1);
    chk("ovf_clr_count", count, 0);

    // Full FIFO, strobe with same-cycle pop
    rx_active = 1'b1; cyc();
    strobe(10'h301, 1); strobe(10'h302, 1); strobe(10'h303, 1); strobe(10'h304, 1);
    read_strobe = 1'b1;
    strobe(10'h305, 1);
    read_strobe = 1'b0;
    chk("wp_error", error, 0);
    chk("wp_count", count, 4);
    len_q.push_back(5);
    rx_active = 1'b0; cyc();
    cyc();
    pop(); pop(); pop(); pop();
    chk("wp_empty", empty, 1);

    // Back-to-back frames: overflow on single-frame, queued on multi-frame
    rx_active = 1'b1; cyc();
    strobe(10'h401, 0); strobe(10'h402, 0);
    len_q.push_back(2);
    rx_active = 1'b0; cyc();
    cyc();
    rx_active = 1'b1; cyc();
    chk("mf0_error", error, 1);
    chk("mf0_code", data, 10'h008);
    chk("mf0_count", count, 2);
    chk("mf0_afull", almost_full, 0);
    strobe(10'h403, 0); strobe(10'h404, 0);
    rx_active = 1'b0; cyc();
    cyc();
    chk("mf1_error", m_error, 0);
    chk("mf1_count", m_count, 4);
    chk("mf1_full", m_full, 1);
    chk("mf0_count_held", count, 2);
    do_clear();
    chk("mf0_clr_empty", empty, 1);
    chk("mf1_clr_empty", m_empty, 1);

    // rx_error mid-frame: first code sticks
    rx_active = 1'b1; cyc();
    strobe(10'h501, 0);
    rx_data = 10'h002; rx_error = 1'b1; cyc(); rx_error = 1'b0;
    chk("rxe_error", error, 1);
    chk("rxe_code", data, 10'h002);
    chk("rxe_count", count, 1);
    strobe(10'h502, 0); strobe(10'h503, 0); strobe(10'h504, 0); strobe(10'h505, 0);
    chk("rxe_code_sticky", data, 10'h002);
    chk("rxe_count_held", count, 1);
    rx_data = 10'h003; rx_error = 1'b1; cyc(); rx_error = 1'b0;
    chk("rxe_first_wins", data, 10'h002);
    rx_active = 1'b0; cyc();
    cyc();
    do_clear();
    chk("rxe_clr_err", error, 0);

    // clear mid-frame -> DRAIN ignores strobes; then async reset mid-frame
    rx_active = 1'b1; cyc();
    strobe(10'h601, 0);
    chk("dr_pre_count", count, 1);
    do_clear();
    strobe(10'h602, 0); strobe(10'h603, 0);
    chk("dr_count", count, 0);
    chk("dr_empty", empty, 1);
    rx_active = 1'b0; cyc();
    cyc();
    rx_active = 1'b1; cyc();
    strobe(10'h701, 0); strobe(10'h702, 0);
    chk("ar_pre_count", count, 2);
    reset_n = 1'b0;
    #2;
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_data", data, 0);
    chk("ar_error", error, 0);
    chk("ar_done", frame_done, 0);
    cyc();
    rx_active = 1'b0;
    reset_n = 1'b1;
    cyc(); cyc();

    chk("sb_words_left", exp_q.size(), 0);
    chk("sb_frames_left", len_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
